// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StOut   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues one word request at a time and hands the
// returned word to decode, holding it across stalls; redirects squash in-flight work.
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] ResetPc   = '0,
  parameter int unsigned          PcStep    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [AddrWidth-1:0] imem_addr_o,
  input  logic [DataWidth-1:0] imem_rdata_i,
  input  logic                 imem_valid_i,
  output logic [DataWidth-1:0] inst_o,
  output logic [AddrWidth-1:0] inst_pc_o,
  output logic                 inst_valid_o,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [AddrWidth-1:0] redirect_pc_i
);

  fetch_state_e         state_q, state_d;
  logic                 req_en_q;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] inst_q, inst_d;
  logic [AddrWidth-1:0] inst_pc_q, inst_pc_d;
  logic                 inst_valid_q, inst_valid_d;

  logic [AddrWidth-1:0] redirect_tgt;
  logic [AddrWidth-1:0] pc_inc;

  assign redirect_tgt = redirect_pc_i & ~AddrWidth'(3);
  assign pc_inc       = pc_q + AddrWidth'(PcStep);

  // req_en_q keeps imem_req low for the reset cycle itself without a path from rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StReq;
      req_en_q     <= 1'b0;
      pc_q         <= ResetPc;
      addr_q       <= ResetPc;
      inst_q       <= DataWidth'(NopInst);
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_en_q     <= 1'b1;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (redirect_i) begin
      pc_d         = redirect_tgt;
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      StReq: begin
        if (!req_en_q) begin
          // No request issued yet, so a redirect simply retargets it.
          if (redirect_i) addr_d = redirect_tgt;
        end else if (redirect_i) begin
          if (imem_valid_i) begin
            addr_d = redirect_tgt;
          end else begin
            state_d = StDrain;
          end
        end else if (imem_valid_i) begin
          inst_d       = imem_rdata_i;
          inst_pc_d    = addr_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_inc;
          state_d      = StOut;
        end
      end
      StOut: begin
        if (redirect_i) begin
          addr_d  = redirect_tgt;
          state_d = StReq;
        end else if (!stall_i) begin
          inst_valid_d = 1'b0;
          addr_d       = pc_q;
          state_d      = StReq;
        end
      end
      StDrain: begin
        // Old address stays on the bus until memory answers; the answer is dropped.
        if (imem_valid_i) begin
          addr_d  = redirect_i ? redirect_tgt : pc_q;
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    imem_req_o   = req_en_q && (state_q != StOut);
    imem_addr_o  = addr_q;
    inst_o       = inst_q;
    inst_pc_o    = inst_pc_q;
    inst_valid_o = inst_valid_q;
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a latency-programmable memory model and a decode-side monitor
// check DUT traffic against expectation queues filled by the stimulus.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch #(
    .DataWidth(32),
    .AddrWidth(32),
    .ResetPc  (32'h0),
    .PcStep   (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .imem_valid_i (imem_valid),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (inst_valid),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } inst_t;

  inst_t       exp_inst_q[$];
  logic [31:0] exp_req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  logic        mem_active = 1'b0;
  logic [31:0] mem_cur = '0;
  int          mem_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00A0_0093 : {16'hC0DE, a[15:0]};
  endfunction

  task automatic push_inst(input logic [31:0] pc, input logic [31:0] data);
    inst_t e;
    e.pc   = pc;
    e.data = data;
    exp_inst_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
    check({tag, "_inst"}, inst, 32'h0000_0013);
    check({tag, "_inst_pc"}, inst_pc, 32'h0);
    check({tag, "_imem_req"}, {31'b0, imem_req}, 32'h0);
  endtask

  task automatic wait_inst(input logic [31:0] pc);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(inst_valid && inst_pc == pc) && n < 60);
    checks++;
    if (!(inst_valid && inst_pc == pc)) begin
      errors++;
      $display("FAIL wait_inst: got valid=%b pc=%h, expected valid inst at %h", inst_valid,
               inst_pc, pc);
    end
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(imem_req && imem_addr == addr) && n < 60);
    checks++;
    if (!(imem_req && imem_addr == addr)) begin
      errors++;
      $display("FAIL wait_req: got req=%b addr=%h, expected request at %h", imem_req,
               imem_addr, addr);
    end
  endtask

  // Memory model: answers each request after mem_lat cycles, checking address order/stability.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (rst) begin
        mem_active = 1'b0;
      end else if (imem_req) begin
        if (!mem_active) begin
          mem_active = 1'b1;
          mem_cnt    = 0;
          mem_cur    = imem_addr;
          if (exp_req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got request at %h, expected none", imem_addr);
          end else begin
            check("req_addr", imem_addr, exp_req_q.pop_front());
          end
        end else begin
          check("req_addr_stable", imem_addr, mem_cur);
        end
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_cur);
          mem_active = 1'b0;
        end
      end
    end
  end

  // Decode-side monitor: every presented instruction is compared; popped once consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && inst_valid === 1'b1) begin
        if (exp_inst_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inst_unexpected: got inst %h at pc %h, expected none", inst, inst_pc);
        end else begin
          check("inst", inst, exp_inst_q[0].data);
          check("inst_pc", inst_pc, exp_inst_q[0].pc);
          if (!stall || redirect) void'(exp_inst_q.pop_front());
        end
        check("req_low_while_out", {31'b0, imem_req}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    foreach (exp_req_q[i]) exp_req_q.delete();
    exp_req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104, 32'hFFFF_FFFC,
                  32'h0, 32'h4, 32'h0};
    push_inst(32'h0, 32'h00A0_0093);
    push_inst(32'h4, 32'hC0DE_0004);
    push_inst(32'h8, 32'hC0DE_0008);
    push_inst(32'hC, 32'hC0DE_000C);
    push_inst(32'h100, 32'hC0DE_0100);
    push_inst(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    push_inst(32'h0, 32'h00A0_0093);
    push_inst(32'h0, 32'h00A0_0093);

    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Zero-wait fetch of address 0, then a 3-cycle access for address 4.
    wait_inst(32'h0);
    mem_lat = 3;
    wait_inst(32'h4);
    mem_lat = 1;
    @(posedge clk);
    #1;
    stall = 1'b1;

    // Hold the word at 8 for five stalled edges.
    wait_inst(32'h8);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    stall = 1'b0;

    // Redirect to 0x103 while the 3-cycle request to 0x10 is pending.
    wait_inst(32'hC);
    mem_lat = 3;
    wait_req(32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    @(posedge clk);
    #1;
    redirect = 1'b0;

    // Redirect coinciding with a response in REQ; target then wraps past the top.
    wait_inst(32'h100);
    mem_lat = 1;
    wait_req(32'h104);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    redirect = 1'b0;

    // Reset while draining a slow request.
    wait_inst(32'h0);
    mem_lat = 4;
    wait_req(32'h4);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check_reset("mid_reset");
    rst     = 1'b0;
    mem_lat = 1;

    wait_inst(32'h0);
    stall = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("req_queue_left", exp_req_q.size(), 32'd0);
    check("inst_queue_left", exp_inst_q.size(), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
Instruction fetch stage, directly upstream of decode.
- Owns the program counter and issues one word request at a time to instruction memory over a req/valid handshake.
- Presents the returned word to decode with its PC, holding it while decode stalls.
- Accepts a redirect (branch/jump target) that squashes any in-flight or held instruction.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, PC / instruction address width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per fetched word

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset, synchronous, active-high
imem_req  out  1  instruction memory request; held high until imem_valid
imem_addr  out  ADDR_WIDTH  request address; stable while imem_req high
imem_rdata  in  DATA_WIDTH  returned instruction word
imem_valid  in  1  imem_rdata valid this cycle; completes the request
inst  out  DATA_WIDTH  instruction to decode
inst_pc  out  ADDR_WIDTH  address of inst
inst_valid  out  1  inst/inst_pc valid for decode
stall  in  1  decode cannot accept; hold current inst
redirect  in  1  load new PC, squash current fetch
redirect_pc  in  ADDR_WIDTH  redirect target

Behaviour:
- Reset state: pc=RESET_PC, state=REQ, addr_q=RESET_PC, inst=NOP_INST (32'h00000013), inst_pc=0, inst_valid=0. imem_req is 0 in the reset cycle and rises in the first cycle after rst deasserts.
- Reset mid-operation aborts everything, including a pending request. Memory shares rst, so no late response is expected.
- All outputs are registered or decoded from the state register only. There is no combinational path from imem_valid or stall to any output.
- States:
  - REQ: imem_req=1, imem_addr=addr_q (=pc). On an edge with imem_valid=1: inst<=imem_rdata, inst_pc<=addr_q, inst_valid<=1, pc<=pc+PC_STEP, go to OUT. A zero-wait memory (imem_valid in the first REQ cycle) gives inst_valid exactly one cycle after imem_req rises.
  - OUT: imem_req=0, inst_valid=1. If stall=0 at the edge, the word is consumed: inst_valid<=0, addr_q<=pc, go to REQ. If stall=1, hold inst/inst_pc/inst_valid unchanged.
  - DRAIN: imem_req=1, imem_addr=addr_q (old address). On imem_valid=1: discard data, addr_q<=pc, go to REQ. inst_valid=0 throughout.
- stall is ignored in REQ and DRAIN.
- Throughput: at most one instruction per 2 cycles, which matches decode's 2-cycle DECODE->PROCESS loop.
- Redirect has highest priority at every edge:
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - inst_valid<=0.
  - In REQ with imem_valid=0: go to DRAIN. The outstanding address is kept on imem_addr until the response arrives, then the response is dropped.
  - In REQ with imem_valid=1 in the same cycle: drop the data, addr_q<=redirect target, stay in REQ.
  - In OUT (stalled or not): drop the held inst, addr_q<=target, go to REQ.
  - In DRAIN: update pc only; remain in DRAIN until imem_valid.
- PC arithmetic is modulo 2^ADDR_WIDTH: {ADDR_WIDTH{1'b1}} & ~3 + 4 wraps to 0.
- imem_req never deasserts before imem_valid, except on rst.

Decomposition:
- Add to config.v: NOP_INST, fetch state encodings (F_REQ, F_OUT, F_DRAIN).
- Single module, no sub-module. The PC register and next-PC mux are small enough to stay inline.

Test Plan:
- Reset then zero-wait memory returning 0x00A00093 at addr 0, stall=0 -> imem_req rises cycle 1, inst_valid=1 with inst=0x00A00093, inst_pc=0 on cycle 2, next imem_addr=4.
- Memory latency 3 cycles -> imem_req held high with imem_addr stable for all 3 cycles; single capture; pc advances by 4 exactly once.
- stall=1 for 5 cycles while in OUT at inst_pc=8 -> inst, inst_pc=8 and inst_valid=1 unchanged, imem_req=0; after stall drops, next request uses addr 0xC.
- redirect=1, redirect_pc=0x103 during a 3-cycle pending request to 0x10 -> DRAIN holds imem_addr=0x10 until imem_valid, data discarded, inst_valid stays 0, next request at 0x100.
- redirect and imem_valid in the same cycle in REQ -> data dropped, next imem_addr = target. Separately, pc=0xFFFFFFFC fetch -> next imem_addr=0x00000000.
- rst asserted in WAIT/DRAIN -> next cycle inst_valid=0, inst=0x00000013, pc=RESET_PC, fresh request to RESET_PC after rst drops.
